// File: rtl/cond_flags_unit_pkg.sv
// ---------------------------------------------------------------------------
// cond_pkg
// Shared types for the branch-condition unit:
//   cond_e     - the sixteen A64 condition codes (EQ = 4'h0 ... NV = 4'hF)
//   br_type_e  - kind of branch request coming from decode
//   state_e    - resolver FSM state encoding (plain vector + constants so the
//                encoding stays stable for older code that pokes at it)
//   nzcv_t     - architectural flag word, packed MSB-first as {N,Z,C,V}
// ---------------------------------------------------------------------------
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0,
    NE = 4'h1,
    CS = 4'h2,
    CC = 4'h3,
    MI = 4'h4,
    PL = 4'h5,
    VS = 4'h6,
    VC = 4'h7,
    HI = 4'h8,
    LS = 4'h9,
    GE = 4'hA,
    LT = 4'hB,
    GT = 4'hC,
    LE = 4'hD,
    AL = 4'hE,
    NV = 4'hF
  } cond_e;

  typedef enum logic [1:0] {
    BR_UNCOND = 2'd0,
    BR_COND   = 2'd1,
    BR_CBZ    = 2'd2,
    BR_CBNZ   = 2'd3
  } br_type_e;

  typedef logic [1:0] state_e;
  localparam state_e ST_IDLE = 2'd0;
  localparam state_e ST_WAIT = 2'd1;
  localparam state_e ST_RESP = 2'd2;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

endpackage

// File: rtl/cond_flags_unit_cond_eval.sv
// ---------------------------------------------------------------------------
// cond_eval
// Purely combinational A64 condition-code evaluator.
// Ports:
//   flags  in  nzcv_t  flag word to test
//   cond   in  cond_e  condition code
//   taken  out 1       condition holds
// ---------------------------------------------------------------------------
module cond_eval
  import cond_pkg::*;
(
  input  nzcv_t flags,
  input  cond_e cond,
  output logic  taken
);

  // AL and NV both fall into the default arm: A64 treats NV as "always".
  always_comb begin
    taken = 1'b1;
    case (cond)
      EQ:      taken = flags.z;
      NE:      taken = !flags.z;
      CS:      taken = flags.c;
      CC:      taken = !flags.c;
      MI:      taken = flags.n;
      PL:      taken = !flags.n;
      VS:      taken = flags.v;
      VC:      taken = !flags.v;
      HI:      taken = flags.c && !flags.z;
      LS:      taken = !(flags.c && !flags.z);
      GE:      taken = (flags.n == flags.v);
      LT:      taken = (flags.n != flags.v);
      GT:      taken = !flags.z && (flags.n == flags.v);
      LE:      taken = !(!flags.z && (flags.n == flags.v));
      default: taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_flags_unit.sv
// ---------------------------------------------------------------------------
// cond_flags_unit
// Owns the architectural NZCV register, counts in-flight flag writers and
// resolves branch requests from decode over a valid/ready request and
// response handshake.
//
// Optional feature: define FLAG_BYPASS_EN to let a BR_COND resolve straight
// from the ALU flags in the cycle the last pending flag writer retires.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   flag_issue               flag-setting op entered the pipe (pending +1)
//   flag_we                  EX-stage flag write this cycle (pending -1)
//   alu_negative/zero/overflow/carry_out  ALU flags, valid with flag_we
//   br_valid, br_ready       branch request handshake
//   br_type, br_cond, br_reg_zero  request payload
//   resp_valid, resp_taken, resp_ready  response handshake
//   flush                    synchronous pipeline flush
//   flags_q                  architectural {N,Z,C,V}
//   pending_full             pending counter at MAX_PENDING
//   err                      sticky protocol error
// ---------------------------------------------------------------------------
module cond_flags_unit
  import cond_pkg::*;
#(
  parameter int MAX_PENDING = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flag_issue,
  input  logic       flag_we,
  input  logic       alu_negative,
  input  logic       alu_zero,
  input  logic       alu_overflow,
  input  logic       alu_carry_out,
  input  logic       br_valid,
  output logic       br_ready,
  input  logic [1:0] br_type,
  input  logic [3:0] br_cond,
  input  logic       br_reg_zero,
  output logic       resp_valid,
  output logic       resp_taken,
  input  logic       resp_ready,
  input  logic       flush,
  output logic [3:0] flags_q,
  output logic       pending_full,
  output logic       err
);

  localparam int CW = $clog2(MAX_PENDING + 1);

  state_e        state_r, state_nxt;
  nzcv_t         flags_r;
  nzcv_t         alu_flags;
  cond_e         cond_r, cond_nxt, eval_cond;
  logic          taken_r, taken_nxt;
  logic [CW-1:0] pending_r, pending_nxt;
  logic          err_r, err_set;
  logic          taken_arch, taken_alu;
  logic          can_bypass;

  assign alu_flags    = {alu_negative, alu_zero, alu_carry_out, alu_overflow};
  assign flags_q      = flags_r;
  assign br_ready     = (state_r == ST_IDLE);
  assign resp_valid   = (state_r == ST_RESP);
  assign resp_taken   = taken_r;
  assign pending_full = (pending_r == CW'(MAX_PENDING));
  assign err          = err_r;

  // In IDLE the request is evaluated straight off the input bus; once
  // parked in WAIT the captured condition is used instead.
  assign eval_cond = (state_r == ST_WAIT) ? cond_r : cond_e'(br_cond);

  cond_eval u_eval_arch (
    .flags (flags_r),
    .cond  (eval_cond),
    .taken (taken_arch)
  );

  cond_eval u_eval_alu (
    .flags (alu_flags),
    .cond  (eval_cond),
    .taken (taken_alu)
  );

  // Bypass only when the op writing flags right now is the last one in
  // flight; a simultaneous issue keeps the count at 1, so the flags on the
  // ALU bus are not the final ones.
`ifdef FLAG_BYPASS_EN
  assign can_bypass = (pending_r == CW'(1)) && flag_we && !flag_issue;
`else
  assign can_bypass = 1'b0;
`endif

  // Pending counter update. Issue and retire in the same cycle cancel out;
  // an overflowing issue or an underflowing retire is dropped and flagged.
  always_comb begin
    pending_nxt = pending_r;
    err_set     = 1'b0;
    if (flag_issue && !flag_we) begin
      if (pending_full) err_set = 1'b1;
      else              pending_nxt = pending_r + CW'(1);
    end else if (flag_we && !flag_issue) begin
      if (pending_r == '0) err_set = 1'b1;
      else                 pending_nxt = pending_r - CW'(1);
    end
  end

  // Resolver FSM. A conditional branch resolves from the architectural
  // flags once nothing is pending, otherwise it parks in WAIT. Flush wins
  // over everything and drops whatever request was captured.
  always_comb begin
    state_nxt = state_r;
    taken_nxt = taken_r;
    cond_nxt  = cond_r;
    case (state_r)
      ST_IDLE: begin
        if (br_valid) begin
          cond_nxt = cond_e'(br_cond);
          case (br_type_e'(br_type))
            BR_UNCOND: begin
              taken_nxt = 1'b1;
              state_nxt = ST_RESP;
            end
            BR_CBZ: begin
              taken_nxt = br_reg_zero;
              state_nxt = ST_RESP;
            end
            BR_CBNZ: begin
              taken_nxt = !br_reg_zero;
              state_nxt = ST_RESP;
            end
            default: begin
              if (pending_r == '0) begin
                taken_nxt = taken_arch;
                state_nxt = ST_RESP;
              end else if (can_bypass) begin
                taken_nxt = taken_alu;
                state_nxt = ST_RESP;
              end else begin
                state_nxt = ST_WAIT;
              end
            end
          endcase
        end
      end
      ST_WAIT: begin
        if (pending_r == '0) begin
          taken_nxt = taken_arch;
          state_nxt = ST_RESP;
        end else if (can_bypass) begin
          taken_nxt = taken_alu;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  // State registers. Flags are written on every flag_we, flush included,
  // because a flush only discards younger work, not the retiring op.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      flags_r   <= '0;
      cond_r    <= EQ;
      taken_r   <= 1'b0;
      pending_r <= '0;
      err_r     <= 1'b0;
    end else begin
      state_r <= state_nxt;
      cond_r  <= cond_nxt;
      taken_r <= taken_nxt;
      if (flag_we) flags_r <= alu_flags;
      if (flush) begin
        pending_r <= '0;
      end else begin
        pending_r <= pending_nxt;
        if (err_set) err_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cond_flags_unit.sv
// ---------------------------------------------------------------------------
// tb_cond_flags_unit
// Directed bench for cond_flags_unit. Expected branch outcomes are queued
// when a request is issued and popped by a monitor on each response
// handshake. Timing-dependent expectations follow FLAG_BYPASS_EN.
// ---------------------------------------------------------------------------
module tb_cond_flags_unit;
  import cond_pkg::*;

`ifdef FLAG_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic       clk;
  logic       reset_n;
  logic       flag_issue, flag_we;
  logic       alu_negative, alu_zero, alu_overflow, alu_carry_out;
  logic       br_valid, br_ready;
  logic [1:0] br_type;
  logic [3:0] br_cond;
  logic       br_reg_zero;
  logic       resp_valid, resp_taken, resp_ready;
  logic       flush;
  logic [3:0] flags_q;
  logic       pending_full, err;

  int checks = 0;
  int errors = 0;
  logic sb_q[$];

  cond_flags_unit #(.MAX_PENDING(3)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .flag_issue    (flag_issue),
    .flag_we       (flag_we),
    .alu_negative  (alu_negative),
    .alu_zero      (alu_zero),
    .alu_overflow  (alu_overflow),
    .alu_carry_out (alu_carry_out),
    .br_valid      (br_valid),
    .br_ready      (br_ready),
    .br_type       (br_type),
    .br_cond       (br_cond),
    .br_reg_zero   (br_reg_zero),
    .resp_valid    (resp_valid),
    .resp_taken    (resp_taken),
    .resp_ready    (resp_ready),
    .flush         (flush),
    .flags_q       (flags_q),
    .pending_full  (pending_full),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic n, input logic z, input logic c, input logic v);
    alu_negative  = n;
    alu_zero      = z;
    alu_carry_out = c;
    alu_overflow  = v;
  endtask

  // Presents one request for a single cycle and queues its outcome.
  task automatic apply_branch(input logic [1:0] t, input logic [3:0] c,
                              input logic rz, input logic exp_taken);
    br_valid    = 1'b1;
    br_type     = t;
    br_cond     = c;
    br_reg_zero = rz;
    sb_q.push_back(exp_taken);
    @(negedge clk);
    check_output("br_ready_idle", int'(br_ready), 1);
    step();
    br_valid = 1'b0;
  endtask

  // Expects a response in the current cycle, then takes it one cycle later.
  task automatic accept_resp(input string name);
    @(negedge clk);
    check_output(name, int'(resp_valid), 1);
    step();
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    @(negedge clk);
    check_output("idle_after_resp", int'({br_ready, resp_valid}), 'b10);
    step();
  endtask

  // Scoreboard monitor: every response handshake consumes one expectation.
  always @(negedge clk) begin
    if (reset_n && resp_valid && resp_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_resp actual=%0h required=none", resp_taken);
      end else begin
        check_output("resp_taken", int'(resp_taken), int'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    reset_n     = 1'b0;
    flag_issue  = 1'b0;
    flag_we     = 1'b0;
    set_alu(0, 0, 0, 0);
    br_valid    = 1'b0;
    br_type     = BR_UNCOND;
    br_cond     = 4'h0;
    br_reg_zero = 1'b0;
    resp_ready  = 1'b0;
    flush       = 1'b0;
    step();
    step();
    reset_n = 1'b1;

    // Reset state
    @(negedge clk);
    check_output("rst_flags_q", int'(flags_q), 0);
    check_output("rst_br_ready", int'(br_ready), 1);
    check_output("rst_resp_valid", int'(resp_valid), 0);
    check_output("rst_resp_taken", int'(resp_taken), 0);
    check_output("rst_pending_full", int'(pending_full), 0);
    check_output("rst_err", int'(err), 0);
    step();

    // Unconditional branch resolves the next cycle
    apply_branch(BR_UNCOND, 4'h0, 1'b0, 1'b1);
    accept_resp("uncond_latency");
    @(negedge clk);
    check_output("uncond_flags_q", int'(flags_q), 0);
    step();

    // N=1,V=0 written while pending goes 1 -> 0, then LT / GE
    flag_issue = 1'b1;
    step();
    flag_issue = 1'b0;
    flag_we    = 1'b1;
    set_alu(1, 0, 0, 0);
    step();
    flag_we = 1'b0;
    set_alu(0, 0, 0, 0);
    @(negedge clk);
    check_output("flags_after_we", int'(flags_q), 'b1000);
    step();
    apply_branch(BR_COND, 4'hB, 1'b0, 1'b1);
    accept_resp("lt_latency");
    apply_branch(BR_COND, 4'hA, 1'b0, 1'b0);
    accept_resp("ge_latency");

    // Two writers in flight, EQ parks in WAIT, last writer sets Z
    flag_issue = 1'b1;
    step();
    step();
    flag_issue = 1'b0;
    apply_branch(BR_COND, 4'h0, 1'b0, 1'b1);
    flag_we = 1'b1;
    set_alu(0, 0, 0, 0);
    @(negedge clk);
    check_output("in_wait", int'({br_ready, resp_valid}), 'b00);
    step();
    set_alu(0, 1, 0, 0);
    step();
    flag_we = 1'b0;
    set_alu(0, 0, 0, 0);
    @(negedge clk);
    check_output("wait_exit_timing", int'(resp_valid), BYP);
    check_output("wait_flags_q", int'(flags_q), 'b0100);
    if (BYP == 0) step();
    accept_resp("wait_resp");

    // Response held off for 5 cycles; a new request must not be taken
    apply_branch(BR_CBNZ, 4'h0, 1'b1, 1'b0);
    br_valid = 1'b1;
    br_type  = BR_UNCOND;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("hold_stable", int'({resp_valid, resp_taken, br_ready}), 'b100);
      step();
    end
    br_valid = 1'b0;
    accept_resp("hold_resp");
    apply_branch(BR_CBZ, 4'h0, 1'b1, 1'b1);
    accept_resp("cbz_latency");
    apply_branch(BR_CBNZ, 4'h0, 1'b0, 1'b1);
    accept_resp("cbnz_latency");

    // Pending counter saturates at 3
    flag_issue = 1'b1;
    step();
    step();
    step();
    @(negedge clk);
    check_output("full_at_3", int'({pending_full, err}), 'b10);
    step();
    flag_issue = 1'b0;
    @(negedge clk);
    check_output("overflow_err", int'({pending_full, err}), 'b11);
    step();
    flag_we = 1'b1;
    step();
    @(negedge clk);
    check_output("not_full_at_2", int'(pending_full), 0);
    step();
    step();
    flag_we = 1'b0;
    @(negedge clk);
    check_output("drain_flags_q", int'(flags_q), 0);
    step();
    apply_branch(BR_COND, 4'h1, 1'b0, 1'b1);
    accept_resp("ne_after_drain");

    // Underflowing flag_we still writes flags and sets err
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    @(negedge clk);
    check_output("rst2_err", int'(err), 0);
    step();
    flag_we = 1'b1;
    set_alu(0, 0, 1, 1);
    step();
    flag_we = 1'b0;
    set_alu(0, 0, 0, 0);
    @(negedge clk);
    check_output("underflow_err", int'(err), 1);
    check_output("underflow_flags_q", int'(flags_q), 'b0011);
    step();
    apply_branch(BR_COND, 4'h8, 1'b0, 1'b1);
    accept_resp("hi_latency");
    apply_branch(BR_COND, 4'h9, 1'b0, 1'b0);
    accept_resp("ls_latency");
    apply_branch(BR_COND, 4'hC, 1'b0, 1'b0);
    accept_resp("gt_latency");
    apply_branch(BR_COND, 4'h7, 1'b0, 1'b0);
    accept_resp("vc_latency");

    // Flush in WAIT together with a flag write carrying C=1
    flag_issue = 1'b1;
    step();
    flag_issue = 1'b0;
    br_valid   = 1'b1;
    br_type    = BR_COND;
    br_cond    = 4'h0;
    step();
    br_valid = 1'b0;
    flush    = 1'b1;
    flag_we  = 1'b1;
    set_alu(0, 0, 1, 0);
    step();
    flush   = 1'b0;
    flag_we = 1'b0;
    set_alu(0, 0, 0, 0);
    @(negedge clk);
    check_output("flush_idle", int'({br_ready, resp_valid}), 'b10);
    check_output("flush_flags_q", int'(flags_q), 'b0010);
    check_output("flush_pending_full", int'(pending_full), 0);
    step();
    apply_branch(BR_COND, 4'h2, 1'b0, 1'b1);
    accept_resp("cs_after_flush");

    step();
    step();
    check_output("sb_drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cond_flags_unit.md
# cond_flags_unit

Branch-condition unit on the consumer side of the ALU flag interface. It owns the architectural NZCV register written by flag-setting ALU ops (ADDS/SUBS/ANDS), tracks in-flight flag writers with a pending counter, and resolves B.cond/CBZ/CBNZ/B requests from decode through a valid/ready request and response handshake. It sits between decode (branch requests, issue notifications) and the EX-stage ALU (negative/zero/overflow/carry_out).

## Interface
- MAX_PENDING, 3, max in-flight flag-setting ops; counter width is $clog2(MAX_PENDING+1)
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- flag_issue  in  1  a flag-setting op entered the pipe; pending +1
- flag_we  in  1  EX-stage flag-setting op this cycle; write NZCV; pending −1
- alu_negative, alu_zero, alu_overflow, alu_carry_out  in  1 each  ALU flags, valid when flag_we
- br_valid  in  1  branch request valid
- br_ready  out  1  high only in IDLE
- br_type  in  2  cond_pkg::br_type_e: BR_UNCOND, BR_COND, BR_CBZ, BR_CBNZ
- br_cond  in  4  A64 condition code, used for BR_COND
- br_reg_zero  in  1  tested register == 0, used for CBZ/CBNZ
- resp_valid  out  1  resolution available
- resp_taken  out  1  branch taken; valid with resp_valid
- resp_ready  in  1  consumer accepts response
- flush  in  1  synchronous pipeline flush
- flags_q  out  4  architectural {N,Z,C,V}
- pending_full  out  1  pending == MAX_PENDING; decode stalls flag_issue
- err  out  1  sticky protocol error

## Operation
- FSM: IDLE, WAIT, RESP.
- IDLE: br_ready=1. On br_valid, capture type/cond/reg_zero:
  - BR_UNCOND: taken=1. CBZ: taken=br_reg_zero. CBNZ: taken=!br_reg_zero. All go to RESP.
  - BR_COND with pending==0: evaluate flags_q, go to RESP.
  - BR_COND with pending>0: go to WAIT, except under bypass (see Configuration).
- WAIT: when pending==0, evaluate flags_q and go to RESP.
- RESP: resp_valid=1. resp_taken holds stable until resp_ready, then go to IDLE.
- Condition evaluation (sub-module cond_eval):
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !(C&!Z); GE N==V; LT N!=V; GT !Z&(N==V); LE !(!Z&(N==V)).
  - AL and NV are always taken.
- Pending counter:
  - flag_issue and flag_we in the same cycle: unchanged.
  - flag_issue when full: ignored, err set.
  - flag_we when pending==0: NZCV still written, count stays 0, err set.
- flush: state goes to IDLE, resp_valid=0, pending=0, and the captured request is dropped. flags_q is kept, and a flag_we in the same cycle still writes it. flush has priority over every other input.

## Timing
- Reset values: flags_q=0000, pending=0, state IDLE, br_ready=1, resp_valid=0, resp_taken=0, pending_full=0, err=0.
- NZCV is written on the clk edge ending a flag_we cycle and is visible on flags_q in the next cycle.
- Request accepted at edge k with no wait: resp_valid=1 from cycle k+1.
- WAIT exit: the state is WAIT when pending first reads 0 in cycle j; resp_valid=1 from cycle j+1.
- resp_valid stays high until the edge where resp_ready=1. br_ready goes high the cycle after.
- Back-to-back throughput: one branch every 2 cycles minimum.

## Configuration
- FLAG_BYPASS_EN defined:
  - Applies when a BR_COND is evaluated in a cycle with pending==1 and flag_we=1, either at IDLE acceptance or in WAIT.
  - The branch evaluates the incoming ALU flags directly and goes to RESP. This saves one cycle.
  - Simultaneous flag_issue in that cycle disqualifies the bypass, because pending stays at 1.
- FLAG_BYPASS_EN undefined:
  - The same case goes to or stays in WAIT.
  - The branch resolves the cycle after, from flags_q.

## Structure
- Package cond_pkg: cond_e with all 16 A64 codes (EQ=4'h0 … NV=4'hF), br_type_e, state_e, and the NZCV struct typedef.
- Sub-module cond_eval: combinational, inputs NZCV struct and cond_e, output taken. Used for both the flags_q path and the bypass path.

## Test plan
- Reset, then br_type=BR_UNCOND, pending 0 → resp_valid at +1 cycle, resp_taken=1, flags_q=0000.
- flag_we with N=1, V=0 while pending 1→0, then BR_COND LT (4'hB) → flags_q=1000, taken=1. GE (4'hA) → taken=0.
- Two flag_issue, then BR_COND EQ → WAIT. Two flag_we, the last with Z=1 → taken=1. Response timing at j+1; with FLAG_BYPASS_EN, one cycle earlier.
- Hold resp_ready=0 for 5 cycles → resp_valid and resp_taken stable, br_ready=0 throughout.
- MAX_PENDING=3: four flag_issue → pending_full=1, err=1, pending stays 3. A flag_we at pending 0 sets err as well.
- flush asserted in WAIT together with flag_we (C=1) → IDLE next cycle, resp_valid=0, pending=0, flags_q=0010.
